// File: rtl/vlog_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : vlog_sync_fifo_if
// Description : Valid/ready handshake bundle for vlog_sync_fifo. It carries
//               the write side (in_valid/in_data/in_ready) and the read side
//               (out_valid/out_data/out_ready) of the FIFO.
//               master : producer/consumer environment driving the FIFO
//               slave  : the FIFO itself
// Revision    : 1.0 - initial release
// ============================================================================
interface vlog_sync_fifo_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;   // producer offers in_data
  logic [WIDTH-1:0] in_data;    // write data
  logic             in_ready;   // FIFO can accept a word
  logic             out_valid;  // head word available
  logic [WIDTH-1:0] out_data;   // head word (show-ahead)
  logic             out_ready;  // consumer takes head word

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/vlog_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vlog_sync_fifo
// Description : Single-clock show-ahead FIFO, DEPTH x WIDTH register array,
//               with occupancy count, almost-full/almost-empty flags and
//               sticky overflow/underflow error bits.
// Ports       : clk          - clock, all state updates on posedge
//               rst_n        - synchronous active-low reset
//               bus          - handshake bundle (slave modport)
//               clr_err      - clears overflow/underflow on next edge
//               count        - occupancy 0..DEPTH
//               almost_full  - count >= AFULL_LVL
//               almost_empty - count <= AEMPTY_LVL
//               overflow     - sticky: write attempted while full
//               underflow    - sticky: read attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
module vlog_sync_fifo #(
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  vlog_sync_fifo_if.slave       bus,
  input  wire logic             clr_err,
  output logic      [CNT_W-1:0] count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Parameter legality is checked once at elaboration.
  initial begin
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
      $fatal(1, "vlog_sync_fifo: DEPTH=%0d must be a power of two >= 2", DEPTH);
    if (AFULL_LVL > DEPTH)
      $fatal(1, "vlog_sync_fifo: AFULL_LVL=%0d exceeds DEPTH=%0d", AFULL_LVL, DEPTH);
    if ($bits(bus.in_data) != WIDTH)
      $fatal(1, "vlog_sync_fifo: interface width differs from WIDTH=%0d", WIDTH);
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             wr_fire;
  logic             rd_fire;
  logic             ovf_evt;
  logic             unf_evt;

  // Flags come straight from the registered count, so they are valid in the
  // same cycle the count changes.
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr];

  // When full, a read still fires but the write is blocked; when empty, the
  // write fires but the read does not (no write-through bypass).
  assign wr_fire = bus.in_valid  && !full;
  assign rd_fire = bus.out_ready && !empty;
  assign ovf_evt = bus.in_valid  && full;
  assign unf_evt = bus.out_ready && empty;

  assign count        = cnt;
  assign almost_empty = (cnt <= CNT_W'(AEMPTY_LVL));

  // A zero threshold would make the compare constant, so it is tied off.
  generate
    if (AFULL_LVL == 0) begin : g_afull_const
      assign almost_full = 1'b1;
    end else begin : g_afull_cmp
      assign almost_full = (cnt >= CNT_W'(AFULL_LVL));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      // A new error event wins over a coincident clear.
      overflow  <= ovf_evt || (overflow  && !clr_err);
      underflow <= unf_evt || (underflow && !clr_err);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wr_fire)
      mem[wr_ptr] <= bus.in_data;
  end

endmodule
`default_nettype wire
